wb_commit_buffer: RTL and testbench
===================================

// Module: wb_commit_buffer
// PURPOSE
//  Parametrised write-back stage: replaces the single-register WB stage with a DEPTH-entry
//  in-order commit buffer between MEM and the register file. Absorbs register-file write
//  stalls (rf_wr_ready), supports a pipeline flush, and gives ID a forwarding lookup into
//  buffered, not-yet-committed writes. Emits the trace-debug interface at commit time.
// PARAMETERS
//  DATA_W   32  register-file data width
//  RADDR_W  5   register index width; index 0 is never written
//  PC_W     32  PC width carried for debug trace
//  DEPTH    4   buffer entries; power of two, >= 2
// PORTS
//  clk               in   1        clock; all state changes on rising edge
//  reset             in   1        synchronous, active-high reset
//  ws_allowin        out  1        buffer can accept an entry this cycle
//  ms_to_ws_valid    in   1        MEM presents a valid entry
//  ms_pc             in   PC_W     entry PC
//  ms_rf_we          in   1        entry writes the register file
//  ms_rf_waddr       in   RADDR_W  destination register
//  ms_rf_wdata       in   DATA_W   write data
//  flush             in   1        discard all buffered entries
//  rf_wr_ready       in   1        register file accepts a write this cycle
//  rf_we             out  1        commit write enable
//  rf_waddr          out  RADDR_W  commit register
//  rf_wdata          out  DATA_W   commit data
//  id_raddr1/2       in   RADDR_W  ID source registers for forwarding lookup
//  fwd_hit1/2        out  1        buffered pending write to id_raddrN exists
//  fwd_data1/2       out  DATA_W   data of youngest matching pending write
//  ws_count          out  log2(DEPTH)+1  occupancy
//  debug_wb_pc       out  PC_W     PC of committing entry
//  debug_wb_rf_we    out  4        {4{commit write}}
//  debug_wb_rf_wnum  out  RADDR_W  committing register
//  debug_wb_rf_wdata out  DATA_W   committing data
// BEHAVIOUR
//  - Reset: count=0, rd/wr pointers=0, all outputs 0 except ws_allowin=1. Storage not cleared.
//  - ws_allowin = (count != DEPTH); registered-state only, no dependence on same-cycle pop.
//  - Push: ms_to_ws_valid & ws_allowin & !flush -> write entry at wr_ptr, wr_ptr++ (mod DEPTH).
//    ms_rf_we is stored as (ms_rf_we & ms_rf_waddr != 0).
//  - Head visible from cycle after push: min latency MEM->commit = 1 cycle.
//  - Commit (pop): head valid & (rf_wr_ready | !head.we) -> rd_ptr++. Non-writing entries
//    retire without waiting on rf_wr_ready.
//  - rf_we = head valid & head.we; rf_waddr/rf_wdata = head fields (0 when empty).
//    rf_we held until rf_wr_ready; the write is taken on the edge where both are 1.
//  - Simultaneous push+pop: count unchanged, both pointers advance. Pointers wrap at DEPTH.
//  - Flush (sync, priority over push/pop): count=0, rd_ptr=wr_ptr=0 next cycle; no
//    commit happens in the flush cycle (rf_we and debug_wb_rf_we forced 0 that cycle).
//  - Reset mid-stall or mid-flush: identical to flush; pending entries are lost.
//  - Forwarding (combinational): scan valid entries with we=1 and waddr==id_raddrN;
//    youngest match wins. id_raddrN==0 -> hit=0, data=0. Incoming MEM entry is not searched.
//    A head entry committing this cycle still reports hit.
//  - Debug: debug_wb_rf_we = {4{pop & head.we}}; debug_wb_pc/wnum/wdata = head fields,
//    all 0 when the buffer is empty.
// STRUCTURE
//  - Package wb_pkg: wb_entry_t {pc, we, waddr, wdata}; DEPTH_W = $clog2(DEPTH).
//  - Sub-module wb_entry_fifo: storage, pointers, count, push/pop/flush.
//  - Top: handshake, commit/debug logic, two-port youngest-match forwarding mux.
// TESTING
//  - After reset: ws_allowin=1, rf_we=0, ws_count=0, debug_wb_rf_we=4'h0.
//  - Push {pc=0x1c000000,we=1,r5,0xDEADBEEF}, rf_wr_ready=1 -> next cycle rf_we=1,r5,
//    debug_wb_rf_we=4'hF; following cycle count=0.
//  - rf_wr_ready=0, push 4 entries -> ws_allowin=0 at count=4; 5th valid not taken;
//    raise ready -> 4 commits in order on consecutive cycles.
//  - Buffer r3=0x11 then r3=0x22, id_raddr1=3 -> fwd_hit1=1, fwd_data1=0x22;
//    id_raddr2=0 -> fwd_hit2=0.
//  - Push with we=1,waddr=0 -> commits with rf_we=0, never forwards.
//  - 3 entries buffered, assert flush with simultaneous push -> count=0 next cycle,
//    no rf_we in flush cycle, flushed push absent.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default geometry for the write-back commit buffer.
// The top derives its own entry type from its parameters; wb_entry_t is the default-width form.
package wb_pkg;

    localparam int WB_DATA_W  = 32;
    localparam int WB_RADDR_W = 5;
    localparam int WB_PC_W    = 32;
    localparam int WB_DEPTH   = 4;
    localparam int DEPTH_W    = $clog2(WB_DEPTH);

    typedef struct packed {
        logic [WB_PC_W-1:0]    pc;
        logic                  we;
        logic [WB_RADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0]  wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// Circular entry store for the commit buffer: pointers, occupancy and push/pop/flush.
// The caller gates push/pop, so push never arrives when full and pop never arrives when empty.
module wb_entry_fifo #(
    parameter type entry_t = wb_pkg::wb_entry_t,
    parameter int  DEPTH   = wb_pkg::WB_DEPTH,
    localparam int DEPTH_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  entry_t             wr_entry,
    output entry_t             head,
    output logic [DEPTH_W-1:0] rd_ptr,
    output logic [DEPTH_W:0]   count,
    output entry_t             entries [DEPTH]
);

    entry_t             mem [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(pop);
        end
    end

    // NOTE: storage has no reset; slots are only ever read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head    = mem[rd_ptr];
    assign entries = mem;

endmodule

// File: rtl/wb_commit_buffer.sv
// In-order write-back commit buffer between MEM and the register file, with
// stall absorption, flush, ID-stage forwarding lookup and commit-time debug trace.
module wb_commit_buffer #(
    parameter int  DATA_W  = 32,
    parameter int  RADDR_W = 5,
    parameter int  PC_W    = 32,
    parameter int  DEPTH   = 4,
    localparam int DEPTH_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               ws_allowin,
    input  logic               ms_to_ws_valid,
    input  logic [PC_W-1:0]    ms_pc,
    input  logic               ms_rf_we,
    input  logic [RADDR_W-1:0] ms_rf_waddr,
    input  logic [DATA_W-1:0]  ms_rf_wdata,
    input  logic               flush,
    input  logic               rf_wr_ready,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    input  logic [RADDR_W-1:0] id_raddr1,
    input  logic [RADDR_W-1:0] id_raddr2,
    output logic               fwd_hit1,
    output logic               fwd_hit2,
    output logic [DATA_W-1:0]  fwd_data1,
    output logic [DATA_W-1:0]  fwd_data2,
    output logic [DEPTH_W:0]   ws_count,
    output logic [PC_W-1:0]    debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [RADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
    } entry_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } fwd_t;

    entry_t             wr_entry;
    entry_t             head;
    entry_t             shown;
    entry_t             entries [DEPTH];
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W:0]   count;
    logic               kill;
    logic               head_valid;
    logic               push;
    logic               pop;
    fwd_t               fwd1;
    fwd_t               fwd2;

    // Reset behaves exactly like a flush: pending entries are dropped and nothing commits.
    assign kill       = flush | reset;
    assign head_valid = (count != '0);
    assign ws_allowin = (count != (DEPTH_W+1)'(DEPTH));
    assign ws_count   = count;

    assign push = ms_to_ws_valid & ws_allowin & ~kill;
    assign pop  = head_valid & ~kill & (rf_wr_ready | ~head.we);

    always_comb begin
        wr_entry.pc    = ms_pc;
        wr_entry.we    = ms_rf_we & (ms_rf_waddr != '0);
        wr_entry.waddr = ms_rf_waddr;
        wr_entry.wdata = ms_rf_wdata;
    end

    wb_entry_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .head     (head),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .entries  (entries)
    );

    // Head fields read as zero while empty so uninitialised storage never leaks out.
    assign shown = head_valid ? head : '0;

    assign rf_we    = head_valid & head.we & ~kill;
    assign rf_waddr = shown.waddr;
    assign rf_wdata = shown.wdata;

    assign debug_wb_rf_we    = {4{pop & head.we}};
    assign debug_wb_pc       = shown.pc;
    assign debug_wb_rf_wnum  = shown.waddr;
    assign debug_wb_rf_wdata = shown.wdata;

    // Walk from oldest to youngest so the last match seen is the youngest one.
    function automatic fwd_t lookup(
        input logic [RADDR_W-1:0] raddr,
        input entry_t             ents [DEPTH],
        input logic [DEPTH_W-1:0] base,
        input logic [DEPTH_W:0]   occ
    );
        fwd_t               res;
        logic [DEPTH_W-1:0] idx;
        // NOTE: every local gets a value before the loop so no path leaves it unassigned.
        res = '0;
        idx = base;
        for (int k = 0; k < DEPTH; k++) begin
            idx = base + DEPTH_W'(k);
            if ((k < int'(occ)) && (raddr != '0) && ents[idx].we && (ents[idx].waddr == raddr)) begin
                res.hit  = 1'b1;
                res.data = ents[idx].wdata;
            end
        end
        return res;
    endfunction

    always_comb begin
        fwd1 = lookup(id_raddr1, entries, rd_ptr, count);
        fwd2 = lookup(id_raddr2, entries, rd_ptr, count);
    end

    assign fwd_hit1  = fwd1.hit;
    assign fwd_data1 = fwd1.data;
    assign fwd_hit2  = fwd2.hit;
    assign fwd_data2 = fwd2.data;

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Scoreboard bench: the driver queues each cycle's stimulus, a monitor replays it
// against a queue-based reference model and compares every DUT output.
module tb_wb_commit_buffer;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int PC_W    = 32;
    localparam int DEPTH   = 4;
    localparam int DEPTH_W = $clog2(DEPTH);

    typedef struct {
        bit                 rst;
        bit                 valid;
        logic [PC_W-1:0]    pc;
        bit                 we;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
        bit                 ready;
        bit                 flush;
        logic [RADDR_W-1:0] r1;
        logic [RADDR_W-1:0] r2;
    } stim_t;

    typedef struct {
        logic [PC_W-1:0]    pc;
        bit                 we;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
    } ref_entry_t;

    logic               clk;
    logic               reset;
    logic               ws_allowin;
    logic               ms_to_ws_valid;
    logic [PC_W-1:0]    ms_pc;
    logic               ms_rf_we;
    logic [RADDR_W-1:0] ms_rf_waddr;
    logic [DATA_W-1:0]  ms_rf_wdata;
    logic               flush;
    logic               rf_wr_ready;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [RADDR_W-1:0] id_raddr1;
    logic [RADDR_W-1:0] id_raddr2;
    logic               fwd_hit1;
    logic               fwd_hit2;
    logic [DATA_W-1:0]  fwd_data1;
    logic [DATA_W-1:0]  fwd_data2;
    logic [DEPTH_W:0]   ws_count;
    logic [PC_W-1:0]    debug_wb_pc;
    logic [3:0]         debug_wb_rf_we;
    logic [RADDR_W-1:0] debug_wb_rf_wnum;
    logic [DATA_W-1:0]  debug_wb_rf_wdata;

    wb_commit_buffer #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .PC_W    (PC_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_rf_wdata       (ms_rf_wdata),
        .flush             (flush),
        .rf_wr_ready       (rf_wr_ready),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .id_raddr1         (id_raddr1),
        .id_raddr2         (id_raddr2),
        .fwd_hit1          (fwd_hit1),
        .fwd_hit2          (fwd_hit2),
        .fwd_data1         (fwd_data1),
        .fwd_data2         (fwd_data2),
        .ws_count          (ws_count),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    stim_t stim_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: buffer contents as a plain queue ----------------
    ref_entry_t mdl [$];
    bit         mdl_known = 1'b0;

    function automatic logic [DATA_W:0] ref_fwd(input logic [RADDR_W-1:0] raddr);
        if (raddr == 0) return '0;
        for (int i = mdl.size() - 1; i >= 0; i--)
            if (mdl[i].we && mdl[i].waddr == raddr) return {1'b1, mdl[i].wdata};
        return '0;
    endfunction

    stim_t             s;
    ref_entry_t        h;
    ref_entry_t        ne;
    bit                kill;
    bit                empty;
    bit                exp_pop;
    logic [DATA_W:0]   f1;
    logic [DATA_W:0]   f2;

    always @(negedge clk) begin
        #2;
        if (stim_q.size() > 0) begin
            s     = stim_q.pop_front();
            kill  = s.rst || s.flush;
            empty = (mdl.size() == 0);
            h     = empty ? '{pc: '0, we: 1'b0, waddr: '0, wdata: '0} : mdl[0];
            exp_pop = !empty && !kill && (s.ready || !h.we);

            check("rf_we", 64'(rf_we), 64'(!empty && h.we && !kill));
            check("debug_wb_rf_we", 64'(debug_wb_rf_we), 64'({4{exp_pop && h.we}}));
            if (mdl_known) begin
                f1 = ref_fwd(s.r1);
                f2 = ref_fwd(s.r2);
                check("ws_allowin", 64'(ws_allowin), 64'(mdl.size() != DEPTH));
                check("ws_count", 64'(ws_count), 64'(mdl.size()));
                check("rf_waddr", 64'(rf_waddr), 64'(h.waddr));
                check("rf_wdata", 64'(rf_wdata), 64'(h.wdata));
                check("debug_wb_pc", 64'(debug_wb_pc), 64'(h.pc));
                check("debug_wb_rf_wnum", 64'(debug_wb_rf_wnum), 64'(h.waddr));
                check("debug_wb_rf_wdata", 64'(debug_wb_rf_wdata), 64'(h.wdata));
                check("fwd_hit1", 64'(fwd_hit1), 64'(f1[DATA_W]));
                check("fwd_data1", 64'(fwd_data1), 64'(f1[DATA_W-1:0]));
                check("fwd_hit2", 64'(fwd_hit2), 64'(f2[DATA_W]));
                check("fwd_data2", 64'(fwd_data2), 64'(f2[DATA_W-1:0]));
            end

            // Advance the model through the coming rising edge.
            if (kill) begin
                mdl.delete();
                if (s.rst) mdl_known = 1'b1;
            end else begin
                ne = '{pc: s.pc, we: s.we && (s.waddr != 0), waddr: s.waddr, wdata: s.wdata};
                if (s.valid && mdl.size() < DEPTH) begin
                    if (exp_pop) void'(mdl.pop_front());
                    mdl.push_back(ne);
                end else if (exp_pop) begin
                    void'(mdl.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input bit rst, input bit valid, input logic [PC_W-1:0] pc, input bit we,
                       input logic [RADDR_W-1:0] waddr, input logic [DATA_W-1:0] wdata,
                       input bit ready, input bit fl,
                       input logic [RADDR_W-1:0] r1, input logic [RADDR_W-1:0] r2);
        stim_t st;
        @(negedge clk);
        reset          = rst;
        ms_to_ws_valid = valid;
        ms_pc          = pc;
        ms_rf_we       = we;
        ms_rf_waddr    = waddr;
        ms_rf_wdata    = wdata;
        rf_wr_ready    = ready;
        flush          = fl;
        id_raddr1      = r1;
        id_raddr2      = r2;
        st = '{rst: rst, valid: valid, pc: pc, we: we, waddr: waddr, wdata: wdata,
               ready: ready, flush: fl, r1: r1, r2: r2};
        stim_q.push_back(st);
    endtask

    task automatic idle(input bit ready, input logic [RADDR_W-1:0] r1, input logic [RADDR_W-1:0] r2);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, ready, 1'b0, r1, r2);
    endtask

    initial begin
        reset = 1'b1; ms_to_ws_valid = 1'b0; ms_pc = '0; ms_rf_we = 1'b0;
        ms_rf_waddr = '0; ms_rf_wdata = '0; flush = 1'b0; rf_wr_ready = 1'b0;
        id_raddr1 = '0; id_raddr2 = '0;

        cyc(1, 0, '0, 0, '0, '0, 0, 0, '0, '0);
        cyc(1, 0, '0, 0, '0, '0, 0, 0, '0, '0);
        idle(1, 0, 0);

        // Single write: commits one cycle after the push.
        cyc(0, 1, 32'h1c00_0000, 1, 5'd5, 32'hDEAD_BEEF, 1, 0, 5'd5, 0);
        idle(1, 5, 0);
        idle(1, 5, 0);

        // Fill under stall; the fifth offer must be refused.
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 32'h1c00_0100 + 32'(4 * i), 1, RADDR_W'(i + 1), 32'hA0 + 32'(i), 0, 0, RADDR_W'(i + 1), 0);
        for (int i = 0; i < 5; i++) idle(1, 2, 4);

        // Youngest-match forwarding.
        cyc(0, 1, 32'h1c00_0200, 1, 5'd3, 32'h11, 0, 0, 3, 0);
        cyc(0, 1, 32'h1c00_0204, 1, 5'd3, 32'h22, 0, 0, 3, 0);
        idle(0, 3, 0);
        for (int i = 0; i < 3; i++) idle(1, 3, 3);

        // Write to r0 must never commit or forward.
        cyc(0, 1, 32'h1c00_0300, 1, 5'd0, 32'h55, 0, 0, 0, 0);
        idle(0, 0, 0);
        idle(1, 0, 0);

        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 32'h1c00_0400 + 32'(4 * i), 1, RADDR_W'(i + 8), 32'hB0 + 32'(i), 0, 0, 8, 9);
        cyc(0, 1, 32'h1c00_0410, 1, 5'd12, 32'hC0, 1, 1, 12, 8);
        idle(1, 12, 8);
        idle(1, 12, 8);

        // Randomised traffic, with occasional flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 99) < 1,
                $urandom_range(0, 99) < 60,
                $urandom(),
                $urandom_range(0, 99) < 80,
                RADDR_W'($urandom_range(0, 7)),
                $urandom(),
                $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) < 3,
                RADDR_W'($urandom_range(0, 7)),
                RADDR_W'($urandom_range(0, 7)));
        end

        // Reset while stalled with entries pending.
        cyc(0, 1, 32'h1c00_0500, 1, 5'd6, 32'h66, 0, 0, 6, 0);
        cyc(0, 1, 32'h1c00_0504, 1, 5'd7, 32'h77, 0, 0, 6, 7);
        cyc(1, 1, 32'h1c00_0508, 1, 5'd6, 32'h88, 1, 0, 6, 7);
        idle(1, 6, 7);
        idle(1, 6, 7);

        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
